// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage with 2-entry skid buffer, flags, sticky overflow and delivery count
// Optional: define ALU_RESULT_PARITY_EN to add out_parity (even parity of out_result).
module alu_result_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_result,
    input  logic                 in_carryout,
    input  logic                 in_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_zero,
    output logic                 out_negative,
    output logic                 out_carryout,
    output logic                 out_overflow,
    input  logic                 clr_sticky,
    output logic                 sticky_ovf,
`ifdef ALU_RESULT_PARITY_EN
    output logic                 out_parity,
`endif
    output logic [CNT_WIDTH-1:0] deliv_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             neg;
`ifdef ALU_RESULT_PARITY_EN
        logic             par;
`endif
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d, in_entry;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   acc_in, acc_out;

    assign acc_in  = in_valid & in_ready;
    assign acc_out = main_valid_q & out_ready;

    // Flags are derived once, at load time, so the outputs are pure flop outputs.
    always_comb begin
        in_entry        = '0;
        in_entry.result = in_result;
        in_entry.carry  = in_carryout;
        in_entry.ovf    = in_overflow;
        in_entry.zero   = (in_result == '0);
        in_entry.neg    = in_result[WIDTH-1];
`ifdef ALU_RESULT_PARITY_EN
        in_entry.par    = ^in_result;
`endif
    end

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q) begin
            if (acc_in) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end else if (acc_out) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (acc_in) begin
                main_d = in_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (acc_in) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            main_q.zero  <= 1'b1;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready     <= 1'b1;
            sticky_ovf   <= 1'b0;
            deliv_count  <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready     <= ~skid_valid_d;
            // A set in the same cycle as a clear takes priority.
            if (acc_in && in_overflow)
                sticky_ovf <= 1'b1;
            else if (clr_sticky)
                sticky_ovf <= 1'b0;
            if (acc_out)
                deliv_count <= deliv_count + 1'b1;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_result   = main_q.result;
    assign out_zero     = main_q.zero;
    assign out_negative = main_q.neg;
    assign out_carryout = main_q.carry;
    assign out_overflow = main_q.ovf;
`ifdef ALU_RESULT_PARITY_EN
    assign out_parity   = main_q.par;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage with randomized traffic
module tb_alu_result_stage;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_carryout, in_overflow;
    logic [W-1:0]  in_result;
    logic          out_valid, out_ready, out_zero, out_negative, out_carryout, out_overflow;
    logic [W-1:0]  out_result;
    logic          clr_sticky, sticky_ovf;
    logic [CW-1:0] deliv_count;
`ifdef ALU_RESULT_PARITY_EN
    logic          out_parity;
`endif

    alu_result_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_carryout(in_carryout), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_negative(out_negative),
        .out_carryout(out_carryout), .out_overflow(out_overflow),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf),
`ifdef ALU_RESULT_PARITY_EN
        .out_parity(out_parity),
`endif
        .deliv_count(deliv_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mcnt     = 0;
    logic msticky  = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: stage occupancy equals accepted-minus-delivered, i.e. the scoreboard depth.
    always @(negedge clk) begin
        if (!reset) begin
            exp_t e;
            chk("out_valid", W'(out_valid), W'(q.size() > 0));
            chk("in_ready", W'(in_ready), W'(q.size() < 2));
            chk("deliv_count", W'(deliv_count), W'(mcnt % (1 << CW)));
            chk("sticky_ovf", W'(sticky_ovf), W'(msticky));
            if (out_valid && q.size() > 0) begin
                e = q[0];
                chk("out_result", out_result, e.r);
                chk("out_carryout", W'(out_carryout), W'(e.c));
                chk("out_overflow", W'(out_overflow), W'(e.o));
                chk("out_zero", W'(out_zero), W'(e.r == 0));
                chk("out_negative", W'(out_negative), W'(e.r >> (W - 1)));
`ifdef ALU_RESULT_PARITY_EN
                chk("out_parity", W'(out_parity), W'($countones(e.r) % 2));
`endif
                if (out_ready) begin
                    void'(q.pop_front());
                    mcnt++;
                end
            end
            if (in_valid && in_ready && in_overflow)
                msticky = 1'b1;
            else if (clr_sticky)
                msticky = 1'b0;
        end
    end

    // One clock of stimulus, entered and left at posedge+1; accepted items are scoreboarded.
    task automatic cycle(input logic v, input logic [W-1:0] r, input logic c, input logic o,
                         input logic rdy, input logic clr);
        exp_t e;
        in_valid = v; in_result = r; in_carryout = c; in_overflow = o;
        out_ready = rdy; clr_sticky = clr;
        @(negedge clk);
        #1;
        if (v && in_ready) begin
            e.r = r; e.c = c; e.o = o;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst out_valid", W'(out_valid), 0);
        chk("rst in_ready", W'(in_ready), 1);
        chk("rst out_zero", W'(out_zero), 1);
        chk("rst out_result", out_result, 0);
        chk("rst out_negative", W'(out_negative), 0);
        chk("rst deliv_count", W'(deliv_count), 0);
        chk("rst sticky_ovf", W'(sticky_ovf), 0);
`ifdef ALU_RESULT_PARITY_EN
        chk("rst out_parity", W'(out_parity), 0);
`endif
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_state();
        q.delete();
        mcnt = 0;
        msticky = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_result = '0; in_carryout = 1'b0; in_overflow = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        async_reset();

        // Single transfer with negative result, carry and overflow.
        cycle(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-pressure fills main and skid, then drains in order.
        cycle(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Sticky set beats a same-cycle clear; a lone clear then drops it.
        cycle(1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full throughput with incrementing results.
        for (int i = 0; i < 100; i++) cycle(1'b1, W'(i + 100), 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Zero result and odd-parity value; out_ready asserted while idle.
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h7, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] r;
            r = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), r, 1'($urandom), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0));
        end

        // Reset in the middle of buffered traffic.
        cycle(1'b1, 32'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
        async_reset();
        cycle(1'b1, 32'hCC, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("scoreboard drained", W'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit result mux (sel: in1 when sel=1, else in0).
- Captures the selected ALU result and its carry/overflow, derives zero/negative flags, and hands results to the consumer over a valid/ready handshake.
- A 2-entry skid buffer lets the upstream run at full rate while in_ready is driven only from a flop.
- Also keeps a sticky overflow flag and a count of delivered results.

Parameters:
- WIDTH, 32, data width of the result path; must match the mux width.
- CNT_WIDTH, 16, width of the delivered-result counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a result this cycle.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid and in_ready are both 1.
- in_result  input  WIDTH  selected ALU result from the mux.
- in_carryout  input  1  carry-out tied to in_result.
- in_overflow  input  1  signed overflow tied to in_result.
- out_valid  output  1  out_* fields hold a valid result.
- out_ready  input  1  consumer accepts; transfer when out_valid and out_ready are both 1.
- out_result  output  WIDTH  buffered result.
- out_zero  output  1  1 when out_result is all zeros.
- out_negative  output  1  out_result[WIDTH-1].
- out_carryout  output  1  buffered carry-out.
- out_overflow  output  1  buffered overflow.
- clr_sticky  input  1  synchronous clear of sticky_ovf.
- sticky_ovf  output  1  set by any accepted input with in_overflow=1; held until cleared.
- deliv_count  output  CNT_WIDTH  number of output transfers since reset.

Behaviour:
- Reset (async, active-high, immediate):
  - out_valid=0, in_ready=1, sticky_ovf=0, deliv_count=0.
  - out_result=0, out_zero=1, out_negative=0, out_carryout=0, out_overflow=0.
  - Skid entry invalid.
- Storage: main register (drives out_*) and skid register, each holding {result, carryout, overflow, valid}.
- Flags: out_zero and out_negative are computed when a result enters the main register and stored in the main register. They are never recomputed combinationally from out_result.
- in_ready is registered and equals NOT skid_valid.
- Latency: an input accepted at edge N appears on out_* after edge N; one cycle when the main register is free.
- Per-edge rules (acc_in = in_valid & in_ready; acc_out = out_valid & out_ready):
  - Main empty, acc_in: load main from input.
  - Main full, acc_out, skid empty, acc_in: load main from input (back-to-back, no bubble).
  - Main full, acc_out, skid full: move skid to main, clear skid. in_ready was 0, so no input is taken.
  - Main full, no acc_out, acc_in: load skid from input; in_ready goes 0 next cycle.
  - Main full, acc_out, no acc_in, skid empty: main goes invalid.
- Ordering: results leave strictly in arrival order and are never dropped or duplicated.
- out_* fields stay stable while out_valid=1 and out_ready=0.
- sticky_ovf:
  - Set on acc_in with in_overflow=1.
  - clr_sticky clears it.
  - If the clear and a set occur in the same cycle, the set wins, so sticky_ovf=1.
- deliv_count:
  - Increments by 1 on each acc_out.
  - Wraps modulo 2^CNT_WIDTH with no saturation.
- Reset mid-operation: buffered results are discarded and the stage returns to reset state on the reset edge, not the clock.
- out_ready may be asserted while out_valid=0; this has no effect.

Optional Feature:
- Macro ALU_RESULT_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit), the even parity (XOR-reduce) of out_result.
  - Computed at load time into the main/skid entries, like the other flags.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert reset mid-clock -> immediately out_valid=0, in_ready=1, out_zero=1, deliv_count=0, sticky_ovf=0.
- Single transfer: in_result=32'h8000_0000, in_carryout=1, in_overflow=1, out_ready=1 -> next cycle out_valid=1, out_negative=1, out_zero=0, out_carryout=1, out_overflow=1; sticky_ovf=1; deliv_count=1 after the handshake.
- Back-pressure: out_ready=0, push 0x1, 0x2 -> in_ready=0 after the second push; out_result holds 0x1; raise out_ready -> 0x1 then 0x2 in consecutive cycles, and in_ready returns to 1.
- Full throughput: in_valid=1 and out_ready=1 for 100 cycles with an incrementing result -> 100 in-order outputs with no bubbles after the first; deliv_count=100.
- Sticky priority: clr_sticky=1 in the same cycle as an accepted in_overflow=1 -> sticky_ovf=1. Then clr_sticky alone -> 0.
- Wrap and zero: CNT_WIDTH=4, deliver 17 results including in_result=0 -> deliv_count=1 and out_zero=1 for the zero result. With ALU_RESULT_PARITY_EN, 32'h0000_0007 -> out_parity=1.
